// File: rtl/ring_byte_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ring_byte_serializer_pkg
// Brief    : State encodings and line-level constants shared by the ring
//            byte serializer, its bus interface and its bit timer.
//            The PARITY encoding stays reserved when SERIALIZER_PARITY_EN is
//            undefined, so state values are identical in both builds.
// Revision : 1.0 - initial release
// ============================================================================
package ring_byte_serializer_pkg;

  // Width of the occupancy and statistics counters on the bus.
  localparam int c_COUNT_W = 32;

  // FSM encoding.
  typedef logic [2:0] state_t;

  localparam state_t c_st_idle     = 3'd0;
  localparam state_t c_st_req      = 3'd1;
  localparam state_t c_st_wait_ack = 3'd2;
  localparam state_t c_st_start    = 3'd3;
  localparam state_t c_st_data     = 3'd4;
  localparam state_t c_st_parity   = 3'd5;
  localparam state_t c_st_stop     = 3'd6;

  // Serial line levels.
  localparam logic c_tx_idle  = 1'b1;
  localparam logic c_tx_start = 1'b0;

endpackage : ring_byte_serializer_pkg
`default_nettype wire

// File: rtl/ring_byte_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : ring_byte_serializer_if
// Brief    : Ring read-port handshake plus serial/status outputs of the
//            ring byte serializer. The slave modport is the serializer, the
//            master modport is the ring buffer / surrounding system.
// Revision : 1.0 - initial release
// ============================================================================
interface ring_byte_serializer_if
  import ring_byte_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic [c_COUNT_W-1:0]  bufferLength;
  logic                  readEnable;
  logic                  dataReadAck;
  logic [DATA_WIDTH-1:0] dataRead;
  logic                  txOut;
  logic                  busy;
  logic [c_COUNT_W-1:0]  bytesSent;
  logic [c_COUNT_W-1:0]  timeoutCount;

  // Ring buffer side: supplies occupancy and popped data, observes the line.
  modport master (
    output bufferLength,
    output dataReadAck,
    output dataRead,
    input  readEnable,
    input  txOut,
    input  busy,
    input  bytesSent,
    input  timeoutCount
  );

  // Serializer side.
  modport slave (
    input  bufferLength,
    input  dataReadAck,
    input  dataRead,
    output readEnable,
    output txOut,
    output busy,
    output bytesSent,
    output timeoutCount
  );

endinterface : ring_byte_serializer_if
`default_nettype wire

// File: rtl/ring_byte_serializer_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : ring_byte_serializer_bit_timer
// Brief    : Free-running 0..CLKS_PER_BIT-1 counter. bitTick marks the last
//            clock of a serial bit; clear restarts the count so every FSM
//            state begins on a fresh bit boundary.
// Revision : 1.0 - initial release
// ============================================================================
module ring_byte_serializer_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitTick
);

  localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_cnt_last = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_cnt_one  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;

  // Count clocks within a bit, wrapping at the terminal count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign bitTick = (r_cnt == c_cnt_last);

endmodule : ring_byte_serializer_bit_timer
`default_nettype wire

// File: rtl/ring_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ring_byte_serializer
// Brief    : Drains the ring buffer one word at a time (readEnable pulse,
//            wait for dataReadAck) and shifts each word out LSB-first as an
//            async-style frame: start bit, data bits, optional even parity,
//            stop bit. Counts completed frames and unanswered pop requests.
// Config   : define SERIALIZER_PARITY_EN to insert the even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module ring_byte_serializer
  import ring_byte_serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ring_byte_serializer_if.slave bus
);

  localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int c_ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [c_IDX_W-1:0]   c_bit_last = c_IDX_W'(DATA_WIDTH - 1);
  localparam logic [c_IDX_W-1:0]   c_idx_one  = c_IDX_W'(1);
  localparam logic [c_ACK_W-1:0]   c_ack_last = c_ACK_W'(ACK_TIMEOUT - 1);
  localparam logic [c_ACK_W-1:0]   c_ack_one  = c_ACK_W'(1);
  localparam logic [c_COUNT_W-1:0] c_cnt_one  = c_COUNT_W'(1);

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_state_clear;
  logic                  w_bit_tick;
  logic                  w_ack_take;
  logic                  w_timeout;
  logic                  w_frame_done;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_IDX_W-1:0]    r_bit_idx;
  logic [c_ACK_W-1:0]    r_ack_cnt;
  logic                  r_tx;
  logic [c_COUNT_W-1:0]  r_bytes_sent;
  logic [c_COUNT_W-1:0]  r_timeouts;
`ifdef SERIALIZER_PARITY_EN
  logic                  r_parity;
`endif

  // Every state entry restarts the bit timer so each bit lasts exactly
  // CLKS_PER_BIT clocks regardless of how long the previous state ran.
  assign w_state_clear = (w_state_next != r_state);

  ring_byte_serializer_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_state_clear),
    .bitTick (w_bit_tick)
  );

  // The ack is only honoured while waiting for it; stray acks are dropped.
  assign w_ack_take   = (r_state == c_st_wait_ack) && bus.dataReadAck;
  assign w_timeout    = (r_state == c_st_wait_ack) && !bus.dataReadAck
                        && (r_ack_cnt == c_ack_last);
  assign w_frame_done = (r_state == c_st_stop) && w_bit_tick;

  // Next-state decode for the pop/serialize sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (bus.bufferLength != '0) begin
          w_state_next = c_st_req;
        end
      end
      c_st_req: begin
        w_state_next = c_st_wait_ack;
      end
      c_st_wait_ack: begin
        if (w_ack_take) begin
          w_state_next = c_st_start;
        end else if (w_timeout) begin
          w_state_next = c_st_idle;
        end
      end
      c_st_start: begin
        if (w_bit_tick) begin
          w_state_next = c_st_data;
        end
      end
      c_st_data: begin
        if (w_bit_tick && (r_bit_idx == c_bit_last)) begin
`ifdef SERIALIZER_PARITY_EN
          w_state_next = c_st_parity;
`else
          w_state_next = c_st_stop;
`endif
        end
      end
`ifdef SERIALIZER_PARITY_EN
      c_st_parity: begin
        if (w_bit_tick) begin
          w_state_next = c_st_stop;
        end
      end
`endif
      c_st_stop: begin
        if (w_bit_tick) begin
          w_state_next = c_st_idle;
        end
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ack wait counter: counts clocks spent in WAIT_ACK, zero elsewhere.
  always_ff @(posedge clk) begin
    if (reset || (r_state != c_st_wait_ack)) begin
      r_ack_cnt <= '0;
    end else begin
      r_ack_cnt <= r_ack_cnt + c_ack_one;
    end
  end

  // Shift register and bit index: load on ack, shift right after each data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
    end else if (w_ack_take) begin
      r_shift   <= bus.dataRead;
      r_bit_idx <= '0;
    end else if ((r_state == c_st_data) && w_bit_tick) begin
      r_shift   <= r_shift >> 1;
      r_bit_idx <= r_bit_idx + c_idx_one;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  // Even parity of the word, captured with it since the shift reg is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_ack_take) begin
      r_parity <= ^bus.dataRead;
    end
  end
`endif

  // Registered line driver: level follows the current state one clock later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx <= c_tx_idle;
    end else begin
      case (r_state)
        c_st_start:  r_tx <= c_tx_start;
        c_st_data:   r_tx <= r_shift[0];
`ifdef SERIALIZER_PARITY_EN
        c_st_parity: r_tx <= r_parity;
`endif
        default:     r_tx <= c_tx_idle;
      endcase
    end
  end

  // Completed-frame and timeout statistics, both wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bytes_sent <= '0;
      r_timeouts   <= '0;
    end else begin
      if (w_frame_done) begin
        r_bytes_sent <= r_bytes_sent + c_cnt_one;
      end
      if (w_timeout) begin
        r_timeouts <= r_timeouts + c_cnt_one;
      end
    end
  end

  assign bus.readEnable   = (r_state == c_st_req);
  assign bus.busy         = (r_state != c_st_idle);
  assign bus.txOut        = r_tx;
  assign bus.bytesSent    = r_bytes_sent;
  assign bus.timeoutCount = r_timeouts;

endmodule : ring_byte_serializer
`default_nettype wire

// File: tb/tb_ring_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_byte_serializer
// Brief    : Self-checking bench: a ring-buffer model with 1-cycle ack feeds
//            the serializer, popped bytes go to a scoreboard queue, and a line
//            monitor captures every frame clock by clock and compares it to
//            the waveform expected for the popped byte.
// Config   : honours SERIALIZER_PARITY_EN for the expected frame shape.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_byte_serializer;
  import ring_byte_serializer_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int AT  = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME = NBITS * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ring_byte_serializer_if #(.DATA_WIDTH(DW)) bus ();

  ring_byte_serializer #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB),
    .ACK_TIMEOUT  (AT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int frames = 0;
  int re_count = 0;
  int overlap = 0;
  bit mon_en = 1'b0;
  bit mon_active = 1'b0;
  bit withhold = 1'b0;
  bit ack_next = 1'b0;
  logic [7:0]  ring_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  rb;
  logic [7:0]  mon_b;
  logic [63:0] mon_w;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected line level for every clock of a frame carrying byte b.
  function automatic logic [63:0] build_wave(input logic [7:0] b);
    logic [63:0] w;
    int bi;
    w = '1;
    for (int i = 0; i < FRAME; i++) begin
      bi = i / CPB;
      if (bi == 0)                          w[i] = 1'b0;
      else if (bi <= DW)                    w[i] = b[bi-1];
      else if ((bi == DW + 1) && (NBITS == DW + 3)) w[i] = ^b;
      else                                  w[i] = 1'b1;
    end
    return w;
  endfunction

  task automatic wait_frames(input int n, input int budget);
    for (int c = 0; c < budget && frames < n; c++) @(negedge clk);
    chk("frames_done", 64'(frames), 64'(n));
  endtask

  // Ring buffer model: ack one cycle after the pop request, scoreboard the byte.
  initial begin
    bus.bufferLength = '0;
    bus.dataReadAck  = 1'b0;
    bus.dataRead     = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.dataReadAck = 1'b0;
      if (ack_next) begin
        ack_next = 1'b0;
        rb = ring_q.pop_front();
        bus.dataRead    = rb;
        bus.dataReadAck = 1'b1;
        exp_q.push_back(rb);
      end
      if (bus.readEnable === 1'b1 && !withhold && ring_q.size() > 0) ack_next = 1'b1;
      bus.bufferLength = 32'(ring_q.size());
    end
  end

  // Line monitor: capture a whole frame from the start edge and score it.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && bus.txOut === 1'b0) begin
        mon_active = 1'b1;
        mon_w = '1;
        mon_w[0] = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          mon_w[i] = bus.txOut;
        end
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 64'd1, 64'd0);
        end else begin
          mon_b = exp_q.pop_front();
          chk("frame", mon_w, build_wave(mon_b));
        end
        frames++;
        mon_active = 1'b0;
      end
    end
  end

  // Count pop requests and flag any that overlap a frame on the wire.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.readEnable === 1'b1) begin
        re_count++;
        if (mon_active) overlap++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  re_base;
    int  cyc_re;
    int  cyc_to;
    int  cyc;
    bit  low_seen;
    bit  found;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readEnable", 64'(bus.readEnable), 64'd0);
    chk("rst_txOut", 64'(bus.txOut), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_bytesSent", 64'(bus.bytesSent), 64'd0);
    chk("rst_timeoutCount", 64'(bus.timeoutCount), 64'd0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Empty ring: nothing happens for 50 cycles
    low_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (bus.txOut !== 1'b1 || bus.busy !== 1'b0) low_seen = 1'b1;
    end
    chk("idle_pops", 64'(re_count), 64'd0);
    chk("idle_line", 64'(low_seen), 64'd0);

    // Single byte 0xA5
    ring_q.push_back(8'hA5);
    wait_frames(1, 200);
    chk("a5_bytesSent", 64'(bus.bytesSent), 64'd1);
    chk("a5_pops", 64'(re_count), 64'd1);

    // Three queued bytes, back to back
    ring_q.push_back(8'h01);
    ring_q.push_back(8'h80);
    ring_q.push_back(8'hFF);
    wait_frames(4, 600);
    chk("burst_bytesSent", 64'(bus.bytesSent), 64'd4);
    chk("burst_pops", 64'(re_count), 64'd4);
    chk("burst_ring_empty", 64'(bus.bufferLength), 64'd0);

    // Withheld ack: one timeout, then retry succeeds
    withhold = 1'b1;
    ring_q.push_back(8'h3C);
    cyc_re = -1;
    cyc_to = -1;
    found  = 1'b0;
    for (cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      if (bus.readEnable === 1'b1 && cyc_re < 0) cyc_re = cyc;
      if (bus.timeoutCount != 0) begin
        cyc_to = cyc;
        found  = 1'b1;
      end
    end
    chk("to_seen", 64'(found), 64'd1);
    chk("to_latency", 64'(cyc_to - cyc_re), 64'(AT + 1));
    chk("to_count", 64'(bus.timeoutCount), 64'd1);
    chk("to_busy", 64'(bus.busy), 64'd0);
    chk("to_txOut", 64'(bus.txOut), 64'd1);
    withhold = 1'b0;
    wait_frames(5, 300);
    chk("retry_bytesSent", 64'(bus.bytesSent), 64'd5);
    chk("retry_timeoutCount", 64'(bus.timeoutCount), 64'd1);

    // Reset in the middle of data bit 3 of 0x5A
    mon_en = 1'b0;
    ring_q.push_back(8'h5A);
    found = 1'b0;
    for (cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      if (bus.txOut === 1'b0) found = 1'b1;
    end
    chk("rst5_start_seen", 64'(found), 64'd1);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    chk("rst5_bit3", 64'(bus.txOut), 64'd1);
    re_base = re_count;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst5_txOut", 64'(bus.txOut), 64'd1);
    chk("rst5_busy", 64'(bus.busy), 64'd0);
    chk("rst5_bytesSent", 64'(bus.bytesSent), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    low_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.txOut !== 1'b1 || bus.busy !== 1'b0) low_seen = 1'b1;
    end
    chk("rst5_quiet_line", 64'(low_seen), 64'd0);
    chk("rst5_no_pop", 64'(re_count), 64'(re_base));
    chk("rst5_bytes_hold", 64'(bus.bytesSent), 64'd0);
    mon_en = 1'b1;

    // Parity-sensitive bytes (parity bit only present when enabled)
    ring_q.push_back(8'h07);
    ring_q.push_back(8'hA5);
    wait_frames(7, 400);
    chk("par_bytesSent", 64'(bus.bytesSent), 64'd2);
    chk("no_overlap", 64'(overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ring_byte_serializer
`default_nettype wire
